// File: rtl/pin_bus_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : pin_bus_pkg
// Brief    : Pin controller register map and scheduler state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package pin_bus_pkg;

  localparam int ADDR_SAMPLE_REG = 7;
  localparam int ADDR_SAMPLE_CNT = 8;
  localparam int POSITION_SHIFT  = 8;

  localparam int STATE_W = 3;
  typedef logic [STATE_W-1:0] sched_state_t;

  localparam sched_state_t S_IDLE   = 3'd0;
  localparam sched_state_t S_GRANT  = 3'd1;
  localparam sched_state_t S_RD_CNT = 3'd2;
  localparam sched_state_t S_RD_SMP = 3'd3;
  localparam sched_state_t S_PUSH   = 3'd4;
  localparam sched_state_t S_NEXT   = 3'd5;

endpackage
`default_nettype wire

// File: rtl/pin_cnt_tracker.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : pin_cnt_tracker
// Brief    : Per-pin last-seen sample counts and saturating lost-sample count.
// Revision : 1.0 - initial release
// ============================================================================
module pin_cnt_tracker #(
  parameter int PIN_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [PIN_W-1:0] pin,
  input  logic [15:0]      rd_cnt,
  input  logic [15:0]      cnt_q,
  input  logic             commit,
  output logic             changed,
  output logic [15:0]      lost_cnt
);

  localparam int c_depth = 2 ** PIN_W;

  logic [15:0] r_last_cnt [c_depth];
  logic [15:0] r_lost_cnt;
  logic [15:0] w_last;
  logic [15:0] w_delta;
  logic [16:0] w_sum;

  // Modulo-2^16 subtraction makes a FFFF->0000 counter wrap look like +1.
  assign w_last   = r_last_cnt[pin];
  assign w_delta  = cnt_q - w_last;
  assign w_sum    = {1'b0, r_lost_cnt} + {1'b0, w_delta - 16'd1};
  assign changed  = (rd_cnt != w_last);
  assign lost_cnt = r_lost_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < c_depth; i++) begin
        r_last_cnt[i] <= '0;
      end
      r_lost_cnt <= '0;
    end else if (commit) begin
      r_last_cnt[pin] <= cnt_q;
      if (w_delta > 16'd1) begin
        r_lost_cnt <= w_sum[16] ? 16'hFFFF : w_sum[15:0];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/pin_sample_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : pin_sample_scheduler
// Brief    : Round-robin poller of pin controllers producing a sample stream,
//            sharing the register bus with a host that always wins.
// Revision : 1.0 - initial release
// ============================================================================
module pin_sample_scheduler #(
  parameter int NUM_PINS = 8,
  parameter int PIN_BASE = 0,
  parameter int ADDR_W   = 19
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              scan_en,
  input  logic              host_req,
  output logic              host_gnt,
  output logic              bus_enable,
  output logic [ADDR_W-1:0] bus_addr,
  output logic              bus_rd,
  input  logic [15:0]       bus_rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [5:0]        out_pin,
  output logic              out_sample,
  output logic [15:0]       out_cnt,
  output logic [15:0]       lost_cnt
);
  import pin_bus_pkg::*;

  localparam int c_pin_w = (NUM_PINS > 1) ? $clog2(NUM_PINS) : 1;
  localparam logic [c_pin_w-1:0] c_last_pin = c_pin_w'(NUM_PINS - 1);

  sched_state_t        r_state;
  sched_state_t        w_next;
  logic [c_pin_w-1:0]  r_pin;
  logic [15:0]         r_cnt_q;
  logic [c_pin_w-1:0]  r_out_pin;
  logic                r_smp_q;
  logic [15:0]         r_out_cnt;
  logic                w_changed;
  logic [ADDR_W-1:0]   w_base;

  pin_cnt_tracker #(
    .PIN_W (c_pin_w)
  ) u_tracker (
    .clk      (clk),
    .reset    (reset),
    .pin      (r_pin),
    .rd_cnt   (bus_rd_data),
    .cnt_q    (r_cnt_q),
    .commit   (r_state == S_RD_SMP),
    .changed  (w_changed),
    .lost_cnt (lost_cnt)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // The host is only considered at IDLE/NEXT so a count/sample pair stays atomic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (host_req) w_next = S_GRANT;
                else if (scan_en) w_next = S_RD_CNT;
      S_GRANT:  if (!host_req) w_next = S_IDLE;
      S_RD_CNT: w_next = w_changed ? S_RD_SMP : S_NEXT;
      S_RD_SMP: w_next = S_PUSH;
      S_PUSH:   if (out_ready) w_next = S_NEXT;
      S_NEXT:   if (host_req) w_next = S_GRANT;
                else if (scan_en) w_next = S_RD_CNT;
                else w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  assign w_base = (ADDR_W'(PIN_BASE) + ADDR_W'(r_pin)) << POSITION_SHIFT;

  always_comb begin
    host_gnt   = 1'b0;
    bus_enable = 1'b0;
    bus_rd     = 1'b0;
    bus_addr   = '0;
    out_valid  = 1'b0;
    case (r_state)
      S_GRANT:  host_gnt = 1'b1;
      S_RD_CNT: begin
        bus_enable = 1'b1;
        bus_rd     = 1'b1;
        bus_addr   = w_base + ADDR_W'(ADDR_SAMPLE_CNT);
      end
      S_RD_SMP: begin
        bus_enable = 1'b1;
        bus_rd     = 1'b1;
        bus_addr   = w_base + ADDR_W'(ADDR_SAMPLE_REG);
      end
      S_PUSH:   out_valid = 1'b1;
      default:  ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pin     <= '0;
      r_cnt_q   <= '0;
      r_out_pin <= '0;
      r_smp_q   <= 1'b0;
      r_out_cnt <= '0;
    end else begin
      if (r_state == S_RD_CNT) begin
        r_cnt_q <= bus_rd_data;
      end
      if (r_state == S_RD_SMP) begin
        r_out_pin <= r_pin;
        r_smp_q   <= bus_rd_data[0];
        r_out_cnt <= r_cnt_q;
      end
      if (r_state == S_NEXT) begin
        r_pin <= (r_pin == c_last_pin) ? '0 : r_pin + 1'b1;
      end
    end
  end

  assign out_pin    = 6'(r_out_pin);
  assign out_sample = r_smp_q;
  assign out_cnt    = r_out_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pin_sample_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_pin_sample_scheduler
// Brief    : Self-checking bench: directed vector table, hand sequences for
//            host/reset corners, and randomized traffic against a model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pin_sample_scheduler;

  localparam int NUM_PINS = 4;
  localparam int PIN_BASE = 1;
  localparam int ADDR_W   = 19;

  logic              clk = 1'b0;
  logic              reset;
  logic              scan_en;
  logic              host_req;
  logic              host_gnt;
  logic              bus_enable;
  logic [ADDR_W-1:0] bus_addr;
  logic              bus_rd;
  logic [15:0]       bus_rd_data;
  logic              out_valid;
  logic              out_ready;
  logic [5:0]        out_pin;
  logic              out_sample;
  logic [15:0]       out_cnt;
  logic [15:0]       lost_cnt;

  logic [15:0] ctrl_cnt [NUM_PINS];
  logic        ctrl_lvl [NUM_PINS];
  int          n_vec = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  pin_sample_scheduler #(
    .NUM_PINS (NUM_PINS),
    .PIN_BASE (PIN_BASE),
    .ADDR_W   (ADDR_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .scan_en     (scan_en),
    .host_req    (host_req),
    .host_gnt    (host_gnt),
    .bus_enable  (bus_enable),
    .bus_addr    (bus_addr),
    .bus_rd      (bus_rd),
    .bus_rd_data (bus_rd_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_pin     (out_pin),
    .out_sample  (out_sample),
    .out_cnt     (out_cnt),
    .lost_cnt    (lost_cnt)
  );

  // Pin controller bank: combinational read data decoded from the bus address.
  int dec_pos;
  int dec_off;
  always_comb begin
    bus_rd_data = '0;
    dec_pos     = int'(bus_addr >> 8) - PIN_BASE;
    dec_off     = int'(bus_addr[7:0]);
    if (bus_enable && bus_rd && dec_pos >= 0 && dec_pos < NUM_PINS) begin
      if (dec_off == 8)      bus_rd_data = ctrl_cnt[dec_pos];
      else if (dec_off == 7) bus_rd_data = {15'd0, ctrl_lvl[dec_pos]};
    end
  end

  function automatic logic [ADDR_W-1:0] cnt_addr(input int p);
    return ADDR_W'(((PIN_BASE + p) * 256) + 8);
  endfunction

  function automatic logic [ADDR_W-1:0] smp_addr(input int p);
    return ADDR_W'(((PIN_BASE + p) * 256) + 7);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_vec++;
    n_bad++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, out_valid, 0);
    check({tag, "_gnt"}, host_gnt, 0);
    check({tag, "_en"}, bus_enable, 0);
    check({tag, "_rd"}, bus_rd, 0);
    check({tag, "_addr"}, bus_addr, 0);
    check({tag, "_pin"}, out_pin, 0);
    check({tag, "_smp"}, out_sample, 0);
    check({tag, "_cnt"}, out_cnt, 0);
    check({tag, "_lost"}, lost_cnt, 0);
  endtask

  // Wait (bounded) for an accepted beat, compare it, then step past it.
  task automatic check_beat(input string tag, input int pin, input logic smp,
                            input logic [15:0] cnt, input logic [15:0] lost);
    int i;
    for (i = 0; i < 200 && !(out_valid && out_ready); i++) @(negedge clk);
    if (!(out_valid && out_ready)) begin
      timeout_fail(tag);
    end else begin
      check({tag, "_pin"}, out_pin, pin);
      check({tag, "_smp"}, out_sample, smp);
      check({tag, "_cnt"}, out_cnt, cnt);
      check({tag, "_lost"}, lost_cnt, lost);
    end
    @(negedge clk);
  endtask

  task automatic clear_and_reset();
    @(negedge clk);
    for (int i = 0; i < NUM_PINS; i++) begin
      ctrl_cnt[i] = '0;
      ctrl_lvl[i] = 1'b0;
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  typedef struct {
    int          pin;
    logic [15:0] cnt;
    logic        lvl;
    int          exp_pin;
    logic        exp_smp;
    logic [15:0] exp_cnt;
    logic [15:0] exp_lost;
  } vec_t;

  vec_t vt [6];

  task automatic apply_vec(input int i);
    @(negedge clk);
    ctrl_cnt[vt[i].pin] = vt[i].cnt;
    ctrl_lvl[vt[i].pin] = vt[i].lvl;
    check_beat($sformatf("vec%0d", i), vt[i].exp_pin, vt[i].exp_smp,
               vt[i].exp_cnt, vt[i].exp_lost);
  endtask

  typedef struct {
    int          pin;
    logic        smp;
    logic [15:0] cnt;
    logic [15:0] lost;
  } beat_t;

  beat_t       exp_q [$];
  beat_t       b;
  logic [15:0] mlast [NUM_PINS];
  logic [15:0] scnt;
  logic [15:0] delta;
  int          mlost;
  int          mp;
  bit          exp_smp;
  int          pos;
  int          off;
  int          p;
  int          k;

  initial begin
    reset     = 1'b1;
    scan_en   = 1'b1;
    host_req  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < NUM_PINS; i++) begin
      ctrl_cnt[i] = '0;
      ctrl_lvl[i] = 1'b0;
    end

    vt[0] = '{2, 16'd1,     1'b1, 2, 1'b1, 16'd1,     16'd0};
    vt[1] = '{0, 16'd5,     1'b0, 0, 1'b0, 16'd5,     16'd4};
    vt[2] = '{0, 16'd9,     1'b1, 0, 1'b1, 16'd9,     16'd7};
    vt[3] = '{3, 16'hFFFE,  1'b0, 3, 1'b0, 16'hFFFE,  16'hFFFD};
    vt[4] = '{3, 16'h0001,  1'b1, 3, 1'b1, 16'h0001,  16'hFFFF};
    vt[5] = '{1, 16'd10,    1'b0, 1, 1'b0, 16'd10,    16'hFFFF};

    repeat (2) @(negedge clk);
    check_reset_outputs("rst0");
    reset = 1'b0;

    for (int i = 0; i < 3; i++) apply_vec(i);

    // Host request during a stalled PUSH is deferred until after the handshake.
    out_ready = 1'b0;
    @(negedge clk);
    ctrl_cnt[1] = 16'd3;
    ctrl_lvl[1] = 1'b0;
    for (k = 0; k < 200 && !out_valid; k++) @(negedge clk);
    if (!out_valid) timeout_fail("host_push_wait");
    host_req = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("host_hold_gnt", host_gnt, 0);
      check("host_hold_valid", out_valid, 1);
    end
    check("host_beat_pin", out_pin, 1);
    check("host_beat_cnt", out_cnt, 3);
    check("host_beat_lost", lost_cnt, 9);
    out_ready = 1'b1;
    @(negedge clk);
    check("host_next_gnt", host_gnt, 0);
    repeat (2) begin
      @(negedge clk);
      check("host_grant_gnt", host_gnt, 1);
      check("host_grant_rd", bus_rd, 0);
      check("host_grant_en", bus_enable, 0);
    end
    host_req = 1'b0;
    @(negedge clk);
    check("host_release_gnt", host_gnt, 0);

    // Reset in RD_SMP drops the beat; the next scan re-reports every nonzero pin.
    @(negedge clk);
    ctrl_cnt[3] = 16'd2;
    ctrl_lvl[3] = 1'b1;
    for (k = 0; k < 200 && !(bus_rd && bus_addr == smp_addr(3)); k++) @(negedge clk);
    if (!(bus_rd && bus_addr == smp_addr(3))) timeout_fail("rst_smp_wait");
    reset = 1'b1;
    @(negedge clk);
    check_reset_outputs("rst1");
    reset = 1'b0;
    @(negedge clk);
    check("rescan_cnt_addr", bus_addr, cnt_addr(0));
    @(negedge clk);
    check("rescan_smp_addr", bus_addr, smp_addr(0));
    @(negedge clk);
    check("rescan_first_valid", out_valid, 1);
    check_beat("rescan0", 0, 1'b1, 16'd9, 16'd8);
    check_beat("rescan1", 1, 1'b0, 16'd3, 16'd10);
    check_beat("rescan2", 2, 1'b1, 16'd1, 16'd10);
    check_beat("rescan3", 3, 1'b1, 16'd2, 16'd11);

    clear_and_reset();
    for (int i = 3; i < 6; i++) apply_vec(i);

    // Randomized traffic against a transaction-level model of the poller.
    clear_and_reset();
    mp = 0;
    exp_smp = 1'b0;
    mlost = 0;
    for (int i = 0; i < NUM_PINS; i++) mlast[i] = '0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      if (cyc < 3500) begin
        if ($urandom_range(0, 7) == 0) begin
          p = int'($urandom_range(0, NUM_PINS - 1));
          ctrl_cnt[p] = ctrl_cnt[p] + 16'($urandom_range(1, 3));
          ctrl_lvl[p] = 1'($urandom_range(0, 1));
        end
        if ($urandom_range(0, 15) == 0) host_req = ~host_req;
        if ($urandom_range(0, 31) == 0) scan_en = ~scan_en;
        out_ready = ($urandom_range(0, 3) != 0);
      end else begin
        host_req  = 1'b0;
        scan_en   = 1'b1;
        out_ready = 1'b1;
      end

      if (host_gnt && bus_enable) check("rnd_gnt_excl", bus_enable, 0);

      if (bus_enable && bus_rd) begin
        pos = int'(bus_addr >> 8) - PIN_BASE;
        off = int'(bus_addr[7:0]);
        if (off == 8) begin
          check("rnd_cnt_pin", pos, mp);
          check("rnd_pair_split", exp_smp, 0);
          if (ctrl_cnt[mp] != mlast[mp]) begin
            exp_smp = 1'b1;
            scnt    = ctrl_cnt[mp];
          end else begin
            mp = (mp + 1) % NUM_PINS;
          end
        end else begin
          check("rnd_smp_addr", pos * 256 + off, mp * 256 + 7);
          check("rnd_smp_expected", exp_smp, 1);
          delta = scnt - mlast[mp];
          if (delta > 16'd1) mlost = (mlost + int'(delta) - 1 > 65535) ? 65535 : mlost + int'(delta) - 1;
          mlast[mp] = scnt;
          exp_q.push_back('{mp, ctrl_lvl[mp], scnt, 16'(mlost)});
          mp = (mp + 1) % NUM_PINS;
          exp_smp = 1'b0;
        end
      end

      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("rnd_unexpected_beat", out_valid, 0);
        end else begin
          b = exp_q.pop_front();
          check("rnd_pin", out_pin, b.pin);
          check("rnd_smp", out_sample, b.smp);
          check("rnd_cnt", out_cnt, b.cnt);
          check("rnd_lost", lost_cnt, b.lost);
        end
      end
    end
    check("rnd_drain", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pin_sample_scheduler.md
# pin_sample_scheduler

Polls a bank of pin controllers over the shared register bus and turns new input-stream samples into a single valid/ready sample stream. It sits between the pin controller bank and the host readback path. It arbitrates the bus between itself and the host interface, with the host always winning. It detects samples that were overwritten before they could be read and counts them.

## Interface
- NUM_PINS, 8, number of pin controllers scanned (1..64)
- PIN_BASE, 0, POSITION of the first scanned controller; pin p sits at POSITION PIN_BASE+p
- ADDR_W, 19, bus address width
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- scan_en  in  1  scanning permitted; when 0, finish current pin and park in IDLE
- host_req  in  1  host wants the bus
- host_gnt  out  1  host owns the bus; the external mux selects the host bus
- bus_enable  out  1  scheduler bus enable
- bus_addr  out  ADDR_W  scheduler bus address
- bus_rd  out  1  scheduler read strobe
- bus_rd_data  in  16  OR of all pin controller data_out; combinational, valid in the same cycle as addr/rd
- out_valid  out  1  sample available
- out_ready  in  1  consumer accepts
- out_pin  out  6  pin index p (0..NUM_PINS-1)
- out_sample  out  1  sampled pin level (sample register bit 0)
- out_cnt  out  16  controller sample_cnt value at the time of read
- lost_cnt  out  16  saturating count of overwritten samples

## Operation
- Register addresses for pin p, with base B=(PIN_BASE+p)<<8:
  - sample register = B+7
  - sample count = B+8
- FSM states: IDLE, GRANT, RD_CNT, RD_SMP, PUSH, NEXT.
- IDLE:
  - host_req=1 -> GRANT.
  - Else scan_en=1 -> RD_CNT with the current pin index.
  - Else stay in IDLE.
- GRANT:
  - host_gnt=1; the scheduler drives bus_enable/bus_rd to 0.
  - Leave to IDLE on the cycle after host_req drops.
- RD_CNT:
  - Drive bus_enable=1, bus_rd=1, bus_addr=B+8; capture bus_rd_data into cnt_q.
  - cnt_q != last_cnt[p] -> RD_SMP; else -> NEXT.
- RD_SMP:
  - Drive B+7 with a read; capture bus_rd_data[0] into smp_q.
  - Compute delta = cnt_q - last_cnt[p], modulo 2^16.
  - If delta > 1, add delta-1 to lost_cnt, saturating at 16'hFFFF.
  - Write last_cnt[p] <= cnt_q.
  - Go to PUSH.
- PUSH:
  - out_valid=1; out_pin/out_sample/out_cnt are held stable.
  - On out_valid & out_ready -> NEXT.
  - host_req is not honored in PUSH; the bus is idle in this state.
- NEXT:
  - The pin index increments, wrapping NUM_PINS-1 -> 0.
  - host_req=1 -> GRANT; else scan_en=1 -> RD_CNT; else -> IDLE.
- Host preemption happens only at IDLE/NEXT. A pin read pair (RD_CNT, RD_SMP) is never split.
- last_cnt[] is a NUM_PINS×16 register array. Counter wrap from FFFF to 0000 is handled by the modulo subtraction.

## Timing
- Reset values:
  - state=IDLE, pin index 0, all last_cnt=0, lost_cnt=0.
  - out_valid=0, out_pin=0, out_sample=0, out_cnt=0.
  - host_gnt=0, bus_enable=0, bus_rd=0, bus_addr=0.
- bus_* and host_gnt are registered by state decode: combinational from the state register, with no input-to-output paths.
- Bus read latency is 0: data is sampled at the clock edge ending the cycle in which the address is driven.
- Per-pin cost, with no new sample: RD_CNT + NEXT = 2 cycles.
- Per-pin cost, with a sample and out_ready high: RD_CNT, RD_SMP, PUSH, NEXT = 4 cycles.
- First out_valid appears 3 cycles after leaving IDLE for a pin with a new sample.
- host_gnt asserts 1 cycle after host_req is seen in IDLE/NEXT. Worst-case grant latency is 3 cycles plus the out_ready stall.
- Reset mid-operation: an abandoned PUSH is dropped and last_cnt is cleared. The first scan after reset therefore reports the current sample of every pin whose cnt != 0.
- scan_en falling mid-pin completes that pin, including PUSH, then goes to IDLE.

## Structure
- Shared package (pin_bus_pkg): ADDR_SAMPLE_REG offset 7, ADDR_SAMPLE_CNT offset 8, POSITION shift 8, and the FSM state encoding.
- One sub-module: pin_cnt_tracker, which holds last_cnt[], the delta computation and the saturating lost_cnt.

## Test plan
- NUM_PINS=4, pin 2 cnt goes 0->1 with level 1, out_ready=1 -> one beat: out_pin=2, out_sample=1, out_cnt=1, lost_cnt=0.
- Pin 0 cnt jumps 5->9 between visits -> beat with out_cnt=9; lost_cnt increases by 3.
- last_cnt=FFFE, cnt=0001 -> delta=3; lost_cnt increases by 2; out_cnt=1.
- host_req asserted while in PUSH with out_ready=0 for 5 cycles -> host_gnt stays 0 until after the handshake, then asserts at NEXT+1; bus_rd=0 throughout GRANT.
- lost_cnt preset near FFFF by repeated jumps -> saturates at FFFF and does not wrap.
- reset asserted in RD_SMP -> next cycle all outputs at reset values, last_cnt cleared; the next scan re-reports every nonzero-count pin.
